// File: rtl/riscv_lsu.sv
// riscv_lsu: RV32I load/store unit between the core memory stage and a word-wide RAM port.
// Sub-word stores are done as read-modify-write; loads are lane-extracted and extended.
`default_nettype none

module riscv_lsu #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [WORD_LENGTH-1:0] req_addr,
  input  logic [WORD_LENGTH-1:0] req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [WORD_LENGTH-1:0] resp_rdata,
  output logic                   resp_err,
  output logic [WORD_LENGTH-1:0] mem_addr,
  output logic                   mem_write_en,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  input  logic [WORD_LENGTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t                   state, state_next;
  logic [2:0]               funct3_q;
  logic [1:0]               lane_q;
  logic [15:0]              wdata_q;
  logic                     accept;
  logic                     misaligned;
  logic                     illegal;
  logic                     req_error;
  logic [7:0]               lane_byte;
  logic [15:0]              lane_half;
  logic [WORD_LENGTH-1:0]   load_data;
  logic [WORD_LENGTH-1:0]   merged;

  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign mem_write_en = (state == WRITE);
  assign accept       = req_valid && req_ready;

  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                      (req_we && req_funct3[2]);
  assign req_error  = misaligned || illegal;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_error)                       state_next = RESP;
          else if (!req_we)                    state_next = LOAD;
          else if (req_funct3[1:0] == 2'b10)   state_next = WRITE;
          else                                 state_next = READ;
        end
      end
      LOAD:    state_next = RESP;
      READ:    state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for SB/SH, both from the live RAM word.
  always_comb begin
    lane_byte = mem_dout[{lane_q, 3'b000} +: 8];
    lane_half = lane_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = mem_dout;
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = '0;
    endcase
    merged = mem_dout;
    if (funct3_q[0]) merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else             merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      lane_q     <= 2'b00;
      wdata_q    <= 16'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q   <= req_funct3;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata[15:0];
            resp_rdata <= '0;
            resp_err   <= req_error;
            if (!req_error) begin
              mem_addr <= {req_addr[WORD_LENGTH-1:2], 2'b00};
              if (req_we && (req_funct3[1:0] == 2'b10)) mem_wdata <= req_wdata;
            end
          end
        end
        LOAD:    resp_rdata <= load_data;
        READ:    mem_wdata  <= merged;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
